// File: rtl/bridge_uart_rx.sv
// 8N1 UART receiver for the bus-bridge RX pin: two-flop synchronizer, mid-bit sampling FSM,
// and a one-entry holding register that reports framing errors and overruns.
module bridge_uart_rx #(
    parameter int CLOCKS_PER_PULSE = 5208,
    parameter int DATA_WIDTH       = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  overrun,
    output logic [2:0]            state_dbg
);
    localparam int HALF = CLOCKS_PER_PULSE / 2;
    localparam int CW   = $clog2(CLOCKS_PER_PULSE);
    localparam int IW   = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    localparam logic [2:0] S_WAIT_IDLE = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_DATA      = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;

    logic                  rx_meta_q, rx_s_q;
    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
    logic                  deliver;

    // Handshake: a byte transfers when data_valid && data_ready at a clk edge; data_valid
    // holds until then, data_out is stable while it is high, data_ready is ignored otherwise.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        deliver      = 1'b0;

        case (state_q)
            S_WAIT_IDLE: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    idx_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
                    cnt_d   = '0;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    if (rx_s_q) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_WAIT_IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;

        // A same-cycle accept frees the holding register, so the new byte replaces the old.
        if (deliver) begin
            if (!data_valid_q || data_ready) begin
                data_out_d   = shift_q;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q    <= 1'b0;
            rx_s_q       <= 1'b0;
            state_q      <= S_WAIT_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
    assign state_dbg  = state_q;

endmodule
